// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: default widths,
// the NOP encoding inserted as a bubble, and the slot record layout.
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_PC_W   = 32;
    localparam int DEFAULT_CNT_W  = 16;

    // MIPS sll $0,$0,0 encodes as all zeros and is the canonical NOP.
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_DATA_W-1:0] inst;
        logic [DEFAULT_PC_W-1:0]   pc4;
    } slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline register: a valid bit plus instruction and
// pc+4 payload. Clearing the slot turns it into a NOP bubble, which is kept
// separate from reset because pc+4 is held on a clear but zeroed on reset.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                PC_W     = DEFAULT_PC_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_inst,
    input  logic [PC_W-1:0]   d_pc4,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_inst,
    output logic [PC_W-1:0]   q_pc4
);

    // Clear beats load so a kill always wins; pc+4 survives a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_inst  <= NOP_INST;
            q_pc4   <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
            q_inst  <= NOP_INST;
        end else if (load) begin
            q_valid <= 1'b1;
            q_inst  <= d_inst;
            q_pc4   <= d_pc4;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// flush-to-bubble and a saturating stall-cycle counter.
// Define PIPE_STAGE_SKID_EN to add a second (skid) slot so that in_ready is
// driven from a register and has no combinational path from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                PC_W     = DEFAULT_PC_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEFAULT),
    parameter int                CNT_W    = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc4,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              accept;
    logic              consume;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d_inst;
    logic [PC_W-1:0]   main_d_pc4;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc4;
    logic              skid_load;
    logic              skid_clear;

    // Ready only depends on skid occupancy, so it comes straight from a flop.
    assign in_ready = ~skid_valid;

    // Main is refilled from skid when skid holds the older word, otherwise
    // from the input; skid only catches a word that main cannot take.
    always_comb begin
        main_d_inst = skid_valid ? skid_inst : in_inst;
        main_d_pc4  = skid_valid ? skid_pc4  : in_pc4;
        main_load   = ~flush & (consume ? (skid_valid | accept) : (accept & ~out_valid));
        main_clear  = flush | (consume & ~skid_valid & ~accept);
        skid_load   = ~flush & accept & out_valid & ~consume;
        skid_clear  = flush | (consume & skid_valid);
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_inst  (in_inst),
        .d_pc4   (in_pc4),
        .q_valid (skid_valid),
        .q_inst  (skid_inst),
        .q_pc4   (skid_pc4)
    );
`else
    // Single slot: accept whenever the slot is empty or is draining this cycle.
    assign in_ready = out_ready | ~out_valid;

    // A flush drops any word accepted on the same edge; a drain with nothing
    // behind it leaves a bubble.
    always_comb begin
        main_d_inst = in_inst;
        main_d_pc4  = in_pc4;
        main_load   = ~flush & accept;
        main_clear  = flush | (consume & ~accept);
    end
`endif

    pipe_slot #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .d_inst  (main_d_inst),
        .d_pc4   (main_d_pc4),
        .q_valid (out_valid),
        .q_inst  (out_inst),
        .q_pc4   (out_pc4)
    );

    // Count cycles a live word waits on downstream; stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A queue of expected words is filled
// on accept and drained on consume; directed scenarios also use constants.
// Build with +define+PIPE_STAGE_SKID_EN to check the skid variant.
module tb_pipe_stage_reg;

    localparam int          CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [31:0]   in_pc4;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc4;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } item_t;

    item_t       sb[$];
    int          exp_cnt;
    logic [31:0] hold_pc4;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W   (32),
        .PC_W     (32),
        .NOP_INST (NOP),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc4   (out_pc4),
        .stall_cnt (stall_cnt)
    );

    function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
        return sb.size() < 2;
`else
        return out_ready || (sb.size() == 0);
`endif
    endfunction

    function automatic logic [64:0] exp_out();
        if (sb.size() > 0) return {1'b1, sb[0].inst, sb[0].pc4};
        return {1'b0, NOP, hold_pc4};
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc4,
                         input logic f, input logic ordy);
        in_valid  = v;
        in_inst   = inst;
        in_pc4    = pc4;
        flush     = f;
        out_ready = ordy;
    endtask

    // Advance one clock and update the scoreboard; ends 1 time unit past the edge.
    task automatic cycle();
        logic  acc;
        logic  con;
        item_t it;
        acc = in_valid && exp_ready();
        con = (sb.size() > 0) && out_ready;
        if ((sb.size() > 0) && !out_ready && (exp_cnt < CNT_MAX)) exp_cnt++;
        it.inst = in_inst;
        it.pc4  = in_pc4;
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (con) void'(sb.pop_front());
            if (acc) sb.push_back(it);
        end
        if (sb.size() > 0) hold_pc4 = sb[0].pc4;
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sb.delete();
        exp_cnt  = 0;
        hold_pc4 = '0;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b0, NOP, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b0, NOP, 32'h0});
        end
        reset_dut();
        drive(1'b1, 32'h8C01_0004, 32'h4, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle();
        cycle();
        vectors++;
        if (stall_cnt !== CW'(exp_cnt)) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_stall: got %0d want %0d", stall_cnt, exp_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b0, NOP, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset_out: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b0, NOP, 32'h0});
        end
        vectors++;
        if (stall_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_stall: got %0d want 0", stall_cnt);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL async_reset_ready: got %b want 1", in_ready);
        end
        reset_dut();
    endtask

    task automatic test_streaming();
        reset_dut();
        drive(1'b1, 32'h8C01_0004, 32'h4, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stream_ready0: got %b want 1", in_ready);
        end
        cycle();
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b1, 32'h8C01_0004, 32'h4}) begin
            miscompares++;
            $display("[TB] FAIL stream_w0: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b1, 32'h8C01_0004, 32'h4});
        end
        drive(1'b1, 32'h0022_1820, 32'h8, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stream_ready1: got %b want 1", in_ready);
        end
        cycle();
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b1, 32'h0022_1820, 32'h8}) begin
            miscompares++;
            $display("[TB] FAIL stream_w1: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b1, 32'h0022_1820, 32'h8});
        end
    endtask

    task automatic test_backpressure();
        logic want_ready;
        reset_dut();
        drive(1'b1, 32'h8C01_0004, 32'h4, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h0022_1820, 32'h8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
`ifdef PIPE_STAGE_SKID_EN
            want_ready = (i == 0);
`else
            want_ready = 1'b0;
`endif
            vectors++;
            if (in_ready !== want_ready) begin
                miscompares++;
                $display("[TB] FAIL bp_ready[%0d]: got %b want %b", i, in_ready, want_ready);
            end
            cycle();
            vectors++;
            if ({out_valid, out_inst, out_pc4} !== {1'b1, 32'h8C01_0004, 32'h4}) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got %h want %h", i, {out_valid, out_inst, out_pc4}, {1'b1, 32'h8C01_0004, 32'h4});
            end
        end
        vectors++;
        if (stall_cnt !== CW'(3)) begin
            miscompares++;
            $display("[TB] FAIL bp_stall: got %0d want 3", stall_cnt);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle();
        vectors++;
`ifdef PIPE_STAGE_SKID_EN
        if ({out_valid, out_inst, out_pc4} !== {1'b1, 32'h0022_1820, 32'h8}) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b1, 32'h0022_1820, 32'h8});
        end
`else
        if ({out_valid, out_inst, out_pc4} !== {1'b0, NOP, 32'h4}) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b0, NOP, 32'h4});
        end
`endif
    endtask

    task automatic test_flush();
        reset_dut();
        drive(1'b1, 32'h8C01_0004, 32'h4, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h0022_1820, 32'h8, 1'b1, 1'b1);
        cycle();
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b0, NOP, 32'h4}) begin
            miscompares++;
            $display("[TB] FAIL flush_out: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b0, NOP, 32'h4});
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle();
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b0, NOP, 32'h4}) begin
            miscompares++;
            $display("[TB] FAIL flush_lost: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b0, NOP, 32'h4});
        end
    endtask

    task automatic test_bubble();
        reset_dut();
        drive(1'b1, 32'h0022_1820, 32'h8, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'hDEAD_BEEF, 32'hC, 1'b0, 1'b1);
        cycle();
        vectors++;
        if ({out_valid, out_inst, out_pc4} !== {1'b0, NOP, 32'h8}) begin
            miscompares++;
            $display("[TB] FAIL bubble_out: got %h want %h", {out_valid, out_inst, out_pc4}, {1'b0, NOP, 32'h8});
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        drive(1'b1, 32'h8C01_0004, 32'h4, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            vectors++;
            if (stall_cnt !== CW'(exp_cnt)) begin
                miscompares++;
                $display("[TB] FAIL sat_count[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt);
            end
        end
        vectors++;
        if (stall_cnt !== CW'(CNT_MAX)) begin
            miscompares++;
            $display("[TB] FAIL sat_top: got %0d want %0d", stall_cnt, CNT_MAX);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        vectors++;
        if (stall_cnt !== CW'(CNT_MAX)) begin
            miscompares++;
            $display("[TB] FAIL sat_hold: got %0d want %0d", stall_cnt, CNT_MAX);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) < 7), $urandom, $urandom,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
            #1;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            end
            cycle();
            vectors++;
            if ({out_valid, out_inst, out_pc4} !== exp_out()) begin
                miscompares++;
                $display("[TB] FAIL b2b_out[%0d]: got %h want %h", i, {out_valid, out_inst, out_pc4}, exp_out());
            end
            vectors++;
            if (stall_cnt !== CW'(exp_cnt)) begin
                miscompares++;
                $display("[TB] FAIL b2b_stall[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        $display("[TB] starting pipe_stage_reg bench");
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_bubble();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
